// File: rtl/prbs5_pkg.sv
// Shared types and constants for the PRBS5 checker slice.
// Generator: x^5+x^3+1, feedback q[2]^q[4], serial output q[4], period 31.
package prbs5_pkg;

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int             PRBS5_LEN    = 5;
  localparam int             PRBS5_PERIOD = 31;
  localparam logic [4:0]     PRBS5_SEED   = 5'b11111;

  // One generator step: shift left, feedback enters at bit 0.
  function automatic logic [PRBS5_LEN-1:0] prbs5_next(input logic [PRBS5_LEN-1:0] state);
    return {state[PRBS5_LEN-2:0], state[2] ^ state[4]};
  endfunction

endpackage

// File: rtl/prbs5_predictor.sv
// History shift register for the checker. Holds the last five enabled
// samples (oldest in bit 4) and predicts the next serial bit from them.
module prbs5_predictor
  import prbs5_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 din,
  output logic [PRBS5_LEN-1:0] hist,
  output logic [PRBS5_LEN-1:0] hist_nxt,
  output logic                 pred
);

  logic [PRBS5_LEN-1:0] expect_hist;

  // Bits [4:1] of the predicted history are just the shifted history;
  // bit 0 is the predicted incoming bit.
  assign expect_hist = prbs5_next(hist);
  assign pred        = expect_hist[0];
  assign hist_nxt    = {expect_hist[PRBS5_LEN-1:1], din};

  // Shift in every enabled sample regardless of checker state.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist <= '0;
    end else if (en) begin
      hist <= hist_nxt;
    end
  end

endmodule

// File: rtl/prbs5_checker.sv
// Self-synchronising PRBS5 checker: locks after LOCK_CNT correct
// predictions, counts mismatches while locked, and drops lock on an error
// burst inside one window or on an all-zero history.
// Optional build macro PRBS5_PERIOD_CHECK_EN adds the period_err output.
//
//   state  | meaning
//   SEARCH | filling history / counting consecutive good predictions
//   LOCKED | tracking the sequence, reporting and counting mismatches
module prbs5_checker
  import prbs5_pkg::*;
#(
  parameter int LOCK_CNT = 8,
  parameter int ERR_THR  = 4,
  parameter int WIN      = 31,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  output logic             lock,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic             stuck
`ifdef PRBS5_PERIOD_CHECK_EN
  ,
  output logic             period_err
`endif
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int WIN_W  = $clog2(WIN);
  localparam int WERR_W = $clog2(ERR_THR + 1);

  state_t               state;
  logic [2:0]           fill_cnt;
  logic [GOOD_W-1:0]    good_cnt;
  logic [WIN_W-1:0]     win_cnt;
  logic [WERR_W-1:0]    win_err;

  logic [PRBS5_LEN-1:0] hist;
  logic [PRBS5_LEN-1:0] hist_nxt;
  logic                 pred;
  logic                 valid;
  logic                 mism;
  logic                 wrap;
  logic [WERR_W-1:0]    win_err_nxt;

  prbs5_predictor u_pred (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .din      (din),
    .hist     (hist),
    .hist_nxt (hist_nxt),
    .pred     (pred)
  );

  // Prediction qualifiers and window bookkeeping for the current sample.
  // An all-zero history is the LFSR lockup state and never predicts.
  always_comb begin
    mism        = din ^ pred;
    valid       = (fill_cnt == 3'(PRBS5_LEN)) && (hist != '0);
    wrap        = (win_cnt == WIN_W'(WIN - 1));
    win_err_nxt = (wrap ? '0 : win_err) + WERR_W'(mism);
  end

  assign lock = (state == LOCKED);

  // Lock FSM, fill/good/window counters, error pulse and error totals.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SEARCH;
      fill_cnt <= '0;
      good_cnt <= '0;
      win_cnt  <= '0;
      win_err  <= '0;
      err      <= 1'b0;
      err_cnt  <= '0;
      stuck    <= 1'b0;
    end else begin
      err <= 1'b0;
      if (en) begin
        if (fill_cnt != 3'(PRBS5_LEN)) begin
          fill_cnt <= fill_cnt + 3'd1;
        end
        case (state)
          SEARCH: begin
            if (valid && !mism) begin
              if (good_cnt == GOOD_W'(LOCK_CNT - 1)) begin
                state    <= LOCKED;
                good_cnt <= '0;
                win_cnt  <= '0;
                win_err  <= '0;
              end else begin
                good_cnt <= good_cnt + 1'b1;
              end
            end else begin
              good_cnt <= '0;
            end
          end
          LOCKED: begin
            win_cnt <= wrap ? '0 : win_cnt + 1'b1;
            win_err <= win_err_nxt;
            if (mism) begin
              err <= 1'b1;
              if (err_cnt != '1) begin
                err_cnt <= err_cnt + 1'b1;
              end
            end
            if (hist_nxt == '0) begin
              stuck    <= 1'b1;
              state    <= SEARCH;
              fill_cnt <= '0;
              good_cnt <= '0;
            end else if (mism && (win_err_nxt == WERR_W'(ERR_THR))) begin
              state    <= SEARCH;
              fill_cnt <= '0;
              good_cnt <= '0;
            end
          end
          default: begin
            state <= SEARCH;
          end
        endcase
      end
    end
  end

`ifdef PRBS5_PERIOD_CHECK_EN
  logic [4:0] per_cnt;
  logic       per_armed;

  // Measure spacing between all-ones histories while locked; the first
  // occurrence after lock only arms the measurement.
  always_ff @(posedge clk) begin
    if (rst) begin
      per_cnt    <= '0;
      per_armed  <= 1'b0;
      period_err <= 1'b0;
    end else if (en) begin
      if (state != LOCKED) begin
        per_armed <= 1'b0;
        per_cnt   <= '0;
      end else if (hist_nxt == PRBS5_SEED) begin
        if (per_armed && (per_cnt != 5'(PRBS5_PERIOD - 1))) begin
          period_err <= 1'b1;
        end
        per_armed <= 1'b1;
        per_cnt   <= '0;
      end else if (per_cnt != '1) begin
        per_cnt <= per_cnt + 5'd1;
      end
    end
  end
`endif

endmodule
